// File: rtl/serial_paralelo_align_if.sv
// Serial receive link bundle: one serial bit in, aligned word and link status out.
interface serial_paralelo_align_if #(
  parameter int unsigned WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;
  logic             sync_lost;

  // Bit source / word consumer side
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  sync_lost
  );

  // Deserializer side
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output sync_lost
  );
endinterface

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel deserializer with comma hunt, lock confirmation and loss-of-sync detection.
module serial_paralelo_align #(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA     = WIDTH'(8'hBC),
  parameter int unsigned     LOCK_COUNT = 4,
  parameter int unsigned     LOSS_COUNT = 2
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  serial_paralelo_align_if.slave   lnk
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned CC_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MC_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(WIDTH - 1);
  localparam logic [CC_W-1:0]  LOCK_MAX      = CC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  LOSS_MAX      = MC_W'(LOSS_COUNT);
  localparam logic             LOCK_ON_FIRST = (LOCK_COUNT == 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    SYNC  = 2'd2
  } state_e;

  state_e           state_q;
  // Only the newest WIDTH-1 bits are kept; the incoming bit completes the window.
  logic [WIDTH-2:0] sr_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [CC_W-1:0]  comma_cnt_q;
  logic [MC_W-1:0]  mis_cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_q;
  logic             active_q;
  logic             sync_lost_q;

  logic [WIDTH-1:0] nw_c;
  logic             comma_c;
  logic             boundary_c;
  logic [BIT_W-1:0] bit_cnt_d;
  logic [CC_W-1:0]  comma_cnt_d;
  logic [MC_W-1:0]  mis_cnt_d;

  // Window including the bit sampled at this edge, word boundary and saturating counter steps
  assign nw_c        = {sr_q, lnk.data_in};
  assign comma_c     = (nw_c == COMMA);
  assign boundary_c  = (bit_cnt_q == LAST_BIT);
  assign bit_cnt_d   = boundary_c ? '0 : bit_cnt_q + BIT_W'(1);
  assign comma_cnt_d = (comma_cnt_q == LOCK_MAX) ? comma_cnt_q : comma_cnt_q + CC_W'(1);
  assign mis_cnt_d   = (mis_cnt_q == LOSS_MAX) ? mis_cnt_q : mis_cnt_q + MC_W'(1);

  // Alignment FSM, shift register and registered outputs
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      mis_cnt_q   <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      sr_q        <= nw_c[WIDTH-2:0];
      sync_lost_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (comma_c) begin
            bit_cnt_q   <= '0;
            comma_cnt_q <= CC_W'(1);
            mis_cnt_q   <= '0;
            state_q     <= LOCK_ON_FIRST ? SYNC : CHECK;
            active_q    <= LOCK_ON_FIRST;
          end
        end
        CHECK: begin
          bit_cnt_q <= bit_cnt_d;
          if (boundary_c) begin
            if (comma_c) begin
              comma_cnt_q <= comma_cnt_d;
              if (comma_cnt_d == LOCK_MAX) begin
                state_q   <= SYNC;
                active_q  <= 1'b1;
                mis_cnt_q <= '0;
              end
            end else begin
              state_q     <= HUNT;
              comma_cnt_q <= '0;
            end
          end
        end
        SYNC: begin
          bit_cnt_q <= bit_cnt_d;
          if (boundary_c) begin
            if (comma_c) begin
              data_out_q <= '0;
              valid_q    <= 1'b0;
              mis_cnt_q  <= '0;
            end else begin
              data_out_q <= nw_c;
              valid_q    <= 1'b1;
            end
          end else if (comma_c) begin
            mis_cnt_q <= mis_cnt_d;
            // A comma off the word grid means the lane slipped; count it toward loss.
            if (mis_cnt_d == LOSS_MAX) begin
              state_q     <= HUNT;
              active_q    <= 1'b0;
              valid_q     <= 1'b0;
              data_out_q  <= '0;
              sync_lost_q <= 1'b1;
              mis_cnt_q   <= '0;
              comma_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

  assign lnk.data_out  = data_out_q;
  assign lnk.valid_out = valid_q;
  assign lnk.active    = active_q;
  assign lnk.sync_lost = sync_lost_q;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed bench for the comma-aligned deserializer (8-bit and 10-bit configurations).
module tb_serial_paralelo_align;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_paralelo_align_if #(.WIDTH(8))  bus_a ();
  serial_paralelo_align_if #(.WIDTH(10)) bus_b ();

  serial_paralelo_align #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_COUNT(2)
  ) dut_a (
    .clk_32f (clk),
    .reset   (reset),
    .lnk     (bus_a.slave)
  );

  serial_paralelo_align #(
    .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .LOSS_COUNT(1)
  ) dut_b (
    .clk_32f (clk),
    .reset   (reset),
    .lnk     (bus_b.slave)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_a.data_in = v[i];
      tick();
    end
  endtask

  task automatic send_b(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_b.data_in = v[i];
      tick();
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] d, input logic v,
                         input logic act, input logic sl);
    check_val({tag, "_data"},      32'(bus_a.data_out),  32'(d));
    check_val({tag, "_valid"},     32'(bus_a.valid_out), 32'(v));
    check_val({tag, "_active"},    32'(bus_a.active),    32'(act));
    check_val({tag, "_sync_lost"}, 32'(bus_a.sync_lost), 32'(sl));
  endtask

  task automatic check_b(input string tag, input logic [9:0] d, input logic v,
                         input logic act, input logic sl);
    check_val({tag, "_data"},      32'(bus_b.data_out),  32'(d));
    check_val({tag, "_valid"},     32'(bus_b.valid_out), 32'(v));
    check_val({tag, "_active"},    32'(bus_b.active),    32'(act));
    check_val({tag, "_sync_lost"}, 32'(bus_b.sync_lost), 32'(sl));
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus_a.data_in = 1'b0;
    bus_b.data_in = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // 3 offset bits then four aligned commas: active at the last comma bit
  task automatic lock_a();
    send_a(32'h0, 3);
    send_a(32'hBCBCBCBC, 32);
  endtask

  initial begin
    logic [7:0] w8;
    logic [9:0] w10;

    reset         = 1'b0;
    bus_a.data_in = 1'b0;
    bus_b.data_in = 1'b0;

    // 1: reset with toggling data, then idle zeros
    for (int i = 0; i < 3; i++) begin
      bus_a.data_in = i[0];
      bus_b.data_in = i[0];
      tick();
    end
    check_a("t1_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check_b("t1_rst_b", 10'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    send_a(32'h0, 16);
    check_a("t1_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: lock with 3-bit offset, then 5A / BC / C3
    do_reset();
    send_a(32'h0, 3);
    send_a(32'hBCBCBC, 24);
    send_a(32'h5E, 7);
    check_a("t2_prelock", 8'h00, 1'b0, 1'b0, 1'b0);
    send_a(32'h0, 1);
    check_a("t2_lock", 8'h00, 1'b0, 1'b1, 1'b0);
    send_a(32'h5A, 8);
    check_a("t2_w5a", 8'h5A, 1'b1, 1'b1, 1'b0);
    w8 = 8'hBC;
    for (int i = 7; i >= 1; i--) begin
      bus_a.data_in = w8[i];
      tick();
      check_a("t2_hold5a", 8'h5A, 1'b1, 1'b1, 1'b0);
    end
    bus_a.data_in = w8[0];
    tick();
    check_a("t2_idle_bc", 8'h00, 1'b0, 1'b1, 1'b0);
    send_a(32'hC3, 8);
    check_a("t2_wc3", 8'hC3, 1'b1, 1'b1, 1'b0);

    // 3: lock attempt aborted by a non-comma boundary word, then relock
    do_reset();
    send_a(32'hBCBCBC, 24);
    send_a(32'h00, 8);
    check_a("t3_abort", 8'h00, 1'b0, 1'b0, 1'b0);
    send_a(32'hBCBCBC, 24);
    send_a(32'h5E, 7);
    check_a("t3_prelock", 8'h00, 1'b0, 1'b0, 1'b0);
    send_a(32'h0, 1);
    check_a("t3_lock", 8'h00, 1'b0, 1'b1, 1'b0);

    // 4: three stray bits shift the commas off the word grid
    do_reset();
    lock_a();
    check_a("t4_lock", 8'h00, 1'b0, 1'b1, 1'b0);
    send_a(32'h0, 3);
    send_a(32'h17, 5);
    check_a("t4_w17", 8'h17, 1'b1, 1'b1, 1'b0);
    send_a(32'h4, 3);
    check_a("t4_mis1", 8'h17, 1'b1, 1'b1, 1'b0);
    send_a(32'h17, 5);
    check_a("t4_w97", 8'h97, 1'b1, 1'b1, 1'b0);
    send_a(32'h2, 2);
    check_a("t4_preloss", 8'h97, 1'b1, 1'b1, 1'b0);
    send_a(32'h0, 1);
    check_a("t4_loss", 8'h00, 1'b0, 1'b0, 1'b1);
    send_a(32'h0, 1);
    check_a("t4_postloss", 8'h00, 1'b0, 1'b0, 1'b0);
    send_a(32'hBCBCBC, 24);
    send_a(32'h5E, 7);
    check_a("t4_prerelock", 8'h00, 1'b0, 1'b0, 1'b0);
    send_a(32'h0, 1);
    check_a("t4_relock", 8'h00, 1'b0, 1'b1, 1'b0);

    // 5: reset mid-word while in SYNC forces a full relock
    do_reset();
    lock_a();
    send_a(32'h5A, 8);
    check_a("t5_w5a", 8'h5A, 1'b1, 1'b1, 1'b0);
    send_a(32'h5, 3);
    reset = 1'b0;
    tick();
    check_a("t5_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    send_a(32'h5A, 8);
    check_a("t5_nolock", 8'h00, 1'b0, 1'b0, 1'b0);

    // 6: 10-bit lane, lock after two commas, loss after one stray comma
    do_reset();
    send_b(32'h17C, 10);
    send_b(32'hBE, 9);
    check_b("t6_prelock", 10'h000, 1'b0, 1'b0, 1'b0);
    send_b(32'h0, 1);
    check_b("t6_lock", 10'h000, 1'b0, 1'b1, 1'b0);
    send_b(32'h2A5, 10);
    check_b("t6_w2a5", 10'h2A5, 1'b1, 1'b1, 1'b0);
    w10 = 10'h02F;
    for (int i = 9; i >= 1; i--) begin
      bus_b.data_in = w10[i];
      tick();
      check_b("t6_hold", 10'h2A5, 1'b1, 1'b1, 1'b0);
    end
    bus_b.data_in = w10[0];
    tick();
    check_b("t6_w02f", 10'h02F, 1'b1, 1'b1, 1'b0);
    send_b(32'h2, 2);
    check_b("t6_preloss", 10'h02F, 1'b1, 1'b1, 1'b0);
    send_b(32'h0, 1);
    check_b("t6_loss", 10'h000, 1'b0, 1'b0, 1'b1);
    send_b(32'h0, 1);
    check_b("t6_postloss", 10'h000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
